// File: rtl/mpeg2_pkg.sv
// mpeg2_pkg: shared widths, zigzag scan table and FSM state encodings for the MPEG-2 encoder blocks.
package mpeg2_pkg;
    localparam int COEF_W     = 16;
    localparam int LEVEL_W    = 12;
    localparam int QS_W       = 5;
    localparam int DIVR_W     = 13;
    localparam int DC_DIVISOR = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DIV, ST_WRITE} qz_state_t;

    // Scan index k -> raster index of the 8x8 block.
    localparam logic [5:0] ZIGZAG [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };
endpackage

// File: rtl/quant_zigzag_udiv.sv
// udiv_serial: restoring unsigned divider, one quotient bit per cycle.
// done is high in the DW-th cycle after start, with the final bit folded into quotient combinationally.
module udiv_serial #(
    parameter int DW = 20,
    parameter int VW = 13
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quotient
);
    localparam int CW = $clog2(DW + 1);

    logic [VW-1:0] r_rem, r_div;
    logic [DW-1:0] r_q;
    logic [CW-1:0] r_cnt;
    logic [VW:0]   w_trial, w_diff;
    logic          w_bit;

    always_comb begin
        w_trial  = {r_rem, r_q[DW-1]};
        w_diff   = w_trial - {1'b0, r_div};
        w_bit    = ~w_diff[VW];
        done     = (r_cnt == CW'(1));
        quotient = {r_q[DW-2:0], w_bit};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rem <= '0;
            r_div <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_rem <= '0;
            r_div <= divisor;
            r_q   <= dividend;
            r_cnt <= CW'(DW);
        end else if (r_cnt != '0) begin
            r_rem <= w_bit ? w_diff[VW-1:0] : w_trial[VW-1:0];
            r_q   <= {r_q[DW-2:0], w_bit};
            r_cnt <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/quant_zigzag.sv
// quant_zigzag: MPEG-2 intra quantiser, raster-order coefficients in, zigzag-order 12-bit levels out.
// Define QUANT_ROUND_EN to round the quotient half-up on magnitude instead of truncating.
module quant_zigzag
    import mpeg2_pkg::*;
#(
    parameter int DIV_CYCLES = 20,
    parameter int SAT_MAX    = 2047
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    output logic               rdy,
    input  logic [QS_W-1:0]    qscale,
    output logic [5:0]         caddr,
    input  logic [COEF_W-1:0]  cq,
    output logic [5:0]         qaddr,
    input  logic [7:0]         qq,
    output logic [5:0]         waddr,
    output logic [LEVEL_W-1:0] wdata,
    output logic               wwren
);
    qz_state_t             r_state;
    logic [5:0]            r_k, r_addr, r_waddr;
    logic [QS_W-1:0]       r_qs;
    logic                  r_rdy, r_wwren, r_neg, r_zero;
    logic [LEVEL_W-1:0]    r_wdata;
    logic [COEF_W-1:0]     w_mag;
    logic [DIVR_W-1:0]     w_divisor;
    logic [DIV_CYCLES-1:0] w_dividend, w_quot;
    logic [LEVEL_W-2:0]    w_sat;
    logic [LEVEL_W-1:0]    w_level;
    logic [5:0]            w_knext;
    logic                  w_start, w_done;

    assign rdy   = r_rdy;
    assign caddr = r_addr;
    assign qaddr = r_addr;
    assign waddr = r_waddr;
    assign wdata = r_wdata;
    assign wwren = r_wwren;

    always_comb begin
        // Unsigned magnitude, so -32768 becomes 32768 without overflow.
        w_mag      = cq[COEF_W-1] ? COEF_W'(0) - cq : cq;
        w_divisor  = (r_k == 6'd0) ? DIVR_W'(DC_DIVISOR) : DIVR_W'(qq) * DIVR_W'(r_qs);
        w_dividend = (r_k == 6'd0) ? DIV_CYCLES'(w_mag) : DIV_CYCLES'({w_mag, 4'b0000});
`ifdef QUANT_ROUND_EN
        w_dividend = w_dividend + DIV_CYCLES'(w_divisor >> 1);
`endif
        // A zero divisor yields an all-ones quotient, which the clamp turns into full scale.
        w_sat   = (w_quot > DIV_CYCLES'(SAT_MAX)) ? (LEVEL_W-1)'(SAT_MAX) : w_quot[LEVEL_W-2:0];
        w_level = r_zero ? '0 : r_neg ? LEVEL_W'(0) - {1'b0, w_sat} : {1'b0, w_sat};
        w_knext = r_k + 6'd1;
        w_start = (r_state == ST_FETCH);
    end

    udiv_serial #(.DW(DIV_CYCLES), .VW(DIVR_W)) u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (w_start),
        .dividend (w_dividend),
        .divisor  (w_divisor),
        .done     (w_done),
        .quotient (w_quot)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_addr  <= '0;
            r_waddr <= '0;
            r_qs    <= '0;
            r_rdy   <= 1'b1;
            r_wwren <= 1'b0;
            r_neg   <= 1'b0;
            r_zero  <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (en) begin
                    r_qs    <= qscale;
                    r_k     <= '0;
                    r_addr  <= ZIGZAG[0];
                    r_rdy   <= 1'b0;
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    r_neg   <= cq[COEF_W-1];
                    r_zero  <= (cq == '0);
                    r_state <= ST_DIV;
                end
                ST_DIV: if (w_done) begin
                    r_wwren <= 1'b1;
                    r_waddr <= r_k;
                    r_wdata <= w_level;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_wwren <= 1'b0;
                    if (r_k == 6'd63) begin
                        r_rdy   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_k     <= w_knext;
                        r_addr  <= ZIGZAG[w_knext];
                        r_state <= ST_FETCH;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_quant_zigzag.sv
// tb_quant_zigzag: table-driven, sequence and randomized checks of quant_zigzag against an arithmetic model.
module tb_quant_zigzag;
    logic        clk = 0, reset_n = 0, en = 0;
    logic [4:0]  qscale = 0;
    logic [5:0]  caddr, qaddr, waddr;
    logic [15:0] cq;
    logic [7:0]  qq;
    logic [11:0] wdata;
    logic        wwren, rdy;
    logic [15:0] cmem [64];
    logic [7:0]  wmem [64];
    logic [11:0] omem [64];
    int          zz [64];
    int          tests = 0, fails = 0;

`ifdef QUANT_ROUND_EN
    localparam logic [11:0] DC_EXP = 12'hFF3;
`else
    localparam logic [11:0] DC_EXP = 12'hFF4;
`endif

    typedef struct {
        int          pat;
        int          w;
        int          qs;
        int          k;
        logic [11:0] exp;
        string       nm;
    } vec_t;
    vec_t vecs [14];

    always #5 clk = ~clk;

    assign cq = cmem[caddr];
    assign qq = wmem[qaddr];

    quant_zigzag dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .rdy     (rdy),
        .qscale  (qscale),
        .caddr   (caddr),
        .cq      (cq),
        .qaddr   (qaddr),
        .qq      (qq),
        .waddr   (waddr),
        .wdata   (wdata),
        .wwren   (wwren)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Zigzag order built by walking the anti-diagonals of the 8x8 block.
    function automatic void build_zz();
        int k, row, col;
        k = 0;
        for (int s = 0; s < 15; s++)
            for (int i = 0; i < 8; i++) begin
                row = (s % 2 == 1) ? i : 7 - i;
                col = s - row;
                if (col >= 0 && col < 8) begin
                    zz[k] = row * 8 + col;
                    k++;
                end
            end
    endfunction

    function automatic logic [11:0] model(input int k, input int qs);
        int r, c, mag, dd, dv, q;
        r   = zz[k];
        c   = int'($signed(cmem[r]));
        mag = (c < 0) ? -c : c;
        if (k == 0) begin dd = mag; dv = 8; end
        else begin dd = 16 * mag; dv = int'(wmem[r]) * qs; end
`ifdef QUANT_ROUND_EN
        dd = dd + dv / 2;
`endif
        if (mag == 0) q = 0;
        else if (dv == 0) q = 2047;
        else q = dd / dv;
        if (q > 2047) q = 2047;
        return 12'((c < 0) ? -q : q);
    endfunction

    task automatic fill(input int pat, input int w);
        for (int i = 0; i < 64; i++) begin
            cmem[i] = (pat == 1) ? 16'(i) : (pat == 5) ? 16'(i - 32) : 16'h0000;
            wmem[i] = 8'(w);
        end
        if (pat == 2) cmem[1] = 16'h8000;
        if (pat == 3) cmem[1] = 16'd100;
        if (pat == 4) cmem[0] = 16'hFF9C;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            cmem[i] = 16'($urandom);
            wmem[i] = 8'($urandom);
        end
        cmem[$urandom_range(0, 63)] = 16'h8000;
        cmem[$urandom_range(0, 63)] = 16'h7FFF;
        cmem[$urandom_range(0, 63)] = 16'h0000;
        wmem[$urandom_range(1, 63)] = 8'h00;
    endtask

    // Called at the negedge just after acceptance; collects writes until rdy returns.
    task automatic wait_check(input string nm, input int qs, input bit busy);
        int cyc = 0, nw = 0, bad = 0;
        for (int i = 0; i < 64; i++) omem[i] = 'x;
        while (!rdy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (wwren) begin
                if (int'(waddr) != nw) bad++;
                if (nw < 64) omem[waddr] = wdata;
                nw++;
            end
            if (busy) en = (cyc == 300);
        end
        chk({nm, " cycles"}, cyc, 1408);
        chk({nm, " writes"}, nw, 64);
        chk({nm, " order"}, bad, 0);
        for (int k = 0; k < 64; k++) chk($sformatf("%s k%0d", nm, k), omem[k], model(k, qs));
    endtask

    task automatic run_block(input string nm, input int qs, input bit busy);
        int g = 0;
        while (!rdy && g < 3000) begin @(negedge clk); g++; end
        @(negedge clk);
        qscale = 5'(qs);
        en = 1;
        @(negedge clk);
        en = 0;
        qscale = ~qscale;
        chk({nm, " rdy fall"}, rdy, 0);
        wait_check(nm, qs, busy);
    endtask

    initial begin
        int last_pat, g;
        build_zz();
        vecs[0]  = '{0, 16, 1, 0,  12'h000, "zero k0"};
        vecs[1]  = '{0, 16, 1, 63, 12'h000, "zero k63"};
        vecs[2]  = '{1, 16, 1, 0,  12'h000, "ramp k0"};
        vecs[3]  = '{1, 16, 1, 1,  12'h001, "ramp k1"};
        vecs[4]  = '{1, 16, 1, 2,  12'h008, "ramp k2"};
        vecs[5]  = '{1, 16, 1, 3,  12'h010, "ramp k3"};
        vecs[6]  = '{1, 16, 1, 63, 12'h03F, "ramp k63"};
        vecs[7]  = '{2, 1,  1, 1,  12'h801, "clamp neg"};
        vecs[8]  = '{3, 16, 2, 1,  12'd50,  "scale qs2"};
        vecs[9]  = '{4, 16, 1, 0,  DC_EXP,  "dc neg"};
        vecs[10] = '{5, 16, 0, 0,  12'hFFC, "qs0 dc"};
        vecs[11] = '{5, 16, 0, 1,  12'h801, "qs0 ac neg"};
        vecs[12] = '{5, 16, 0, 10, 12'h000, "qs0 ac zero"};
        vecs[13] = '{5, 16, 0, 63, 12'h7FF, "qs0 ac pos"};
        fill(0, 16);

        repeat (2) @(negedge clk);
        chk("reset rdy", rdy, 1);
        chk("reset wwren", wwren, 0);
        chk("reset caddr", caddr, 0);
        chk("reset qaddr", qaddr, 0);
        chk("reset waddr", waddr, 0);
        chk("reset wdata", wdata, 0);
        reset_n = 1;

        last_pat = -1;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].pat != last_pat) begin
                fill(vecs[i].pat, vecs[i].w);
                run_block($sformatf("pat%0d", vecs[i].pat), vecs[i].qs, 0);
                last_pat = vecs[i].pat;
            end
            chk(vecs[i].nm, omem[vecs[i].k], vecs[i].exp);
        end

        // en held high across the end of a block restarts immediately.
        fill(1, 16);
        @(negedge clk);
        qscale = 1;
        en = 1;
        @(negedge clk);
        chk("hold rdy fall", rdy, 0);
        wait_check("hold1", 1, 0);
        @(negedge clk);
        chk("hold restart", rdy, 0);
        en = 0;
        wait_check("hold2", 1, 0);

        for (int b = 0; b < 5; b++) begin
            fill_random();
            run_block($sformatf("rnd%0d", b), (b == 0) ? 0 : (b == 1) ? 31 : int'($urandom_range(1, 31)), b == 2);
        end

        // Reset around cycle 500, landing on a write cycle.
        fill(1, 16);
        @(negedge clk);
        qscale = 3;
        en = 1;
        @(negedge clk);
        en = 0;
        repeat (500) @(negedge clk);
        g = 0;
        while (!wwren && g < 40) begin @(negedge clk); g++; end
        chk("midreset saw write", wwren, 1);
        #2 reset_n = 0;
        #1;
        chk("midreset wwren", wwren, 0);
        chk("midreset rdy", rdy, 1);
        chk("midreset caddr", caddr, 0);
        chk("midreset waddr", waddr, 0);
        repeat (2) @(negedge clk);
        reset_n = 1;
        fill_random();
        run_block("after reset", int'($urandom_range(1, 31)), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
